dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, 64, number of 32-bit words stored; power of two, 4 to 4096.
REQ-002 Parameter: WAIT_CYCLES, 2, wait states inserted per access; 0 to 15.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: MemReadM  input  1  load request from the memory stage.
REQ-006 Port: MemWriteM  input  1  store request from the memory stage.
REQ-007 Port: ALUResultM  input  32  byte address of the access.
REQ-008 Port: WriteDataM  input  32  store data; right-justified for byte and half stores.
REQ-009 Port: funct3M  input  3  access size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
REQ-010 Port: ReadDataM  output  32  load result, valid only in RESP.
REQ-011 Port: MemStallM  output  1  stall request to the hazard unit; freezes the F, D, E and M stages.
REQ-012 Port: MisalignM  output  1  one-cycle error flag in RESP for a misaligned or illegal-size access.

Function
REQ-013 FSM states: IDLE, WAIT, RESP; encoding is free.
REQ-014 IDLE with no request -> stay in IDLE; MemStallM=0; ReadDataM=0; MisalignM=0.
REQ-015 IDLE with a request, WAIT_CYCLES>0 -> latch address, data and funct3; load wait counter with WAIT_CYCLES-1; go to WAIT.
REQ-016 IDLE with a request, WAIT_CYCLES=0 -> latch the same fields; go directly to RESP.
REQ-017 WAIT: decrement the counter each cycle; go to RESP in the cycle after the counter reads 0.
REQ-018 RESP -> IDLE unconditionally; the pipeline advances at the end of the RESP cycle.
REQ-019 MemStallM is combinational: 1 in IDLE while a request is present, 1 throughout WAIT, 0 in RESP.
REQ-020 Latency: a request first seen in cycle N gives stall in cycles N..N+WAIT_CYCLES and RESP in cycle N+WAIT_CYCLES+1.
REQ-021 Word index = latched address bits [log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo the memory size.
REQ-022 Store commit: the array is updated on the clock edge that enters RESP.
REQ-023 Store lanes: sb writes the one byte lane selected by addr[1:0]; sh writes the half selected by addr[1]; sw writes all four lanes.
REQ-024 Load data is driven from the array in RESP, using the latched address.
REQ-025 Load extension: lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word unchanged.
REQ-026 Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
REQ-027 Illegal size: funct3M of 011, 110 or 111.
REQ-028 On a misaligned or illegal-size access -> no array write, ReadDataM=0, MisalignM=1 in RESP only; the timing is unchanged.
REQ-029 MemReadM and MemWriteM both high -> treated as a store; ReadDataM=0 in RESP.
REQ-030 Request inputs are ignored in WAIT and RESP; the latched values are authoritative.
REQ-031 Request deasserted during WAIT -> the access still completes.
REQ-032 ReadDataM is 0 in every state except RESP of a legal load.

Reset
REQ-033 Reset has priority over all other inputs.
REQ-034 Reset -> next state IDLE; wait counter 0; latched registers 0.
REQ-035 Outputs with reset asserted: MemStallM=0, ReadDataM=0, MisalignM=0.
REQ-036 Reset does not clear the storage array.
REQ-037 Reset during WAIT -> cancels the pending store; the array is unmodified.
REQ-038 Reset during RESP -> a store already committed remains committed.
REQ-039 A request present in the first cycle after reset deasserts is accepted normally.

Verification
REQ-040 WAIT_CYCLES=2: sw 0xDEADBEEF to 0x10 at cycle 0 -> MemStallM=1 in cycles 0-2, RESP in cycle 3; then lw 0x10 -> ReadDataM=0xDEADBEEF in its RESP.
REQ-041 After word 0x10 = 0xDEADBEEF: sb 0x7F to 0x11 -> word 0xDEAD7FEF; lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x12 -> 0xFFFFDEAD.
REQ-042 lw 0x12 -> MisalignM=1 and ReadDataM=0 in RESP; sh to 0x11 -> MisalignM=1 and the stored word is unchanged on readback.
REQ-043 DEPTH_WORDS=64: sw 0x12345678 to 0x100 -> lw 0x0 returns 0x12345678 (wrap-around).
REQ-044 Reset asserted mid-WAIT of sw 0xAAAAAAAA to 0x20 (old value 0x0) -> IDLE next cycle, MemStallM=0; lw 0x20 returns 0x0.
REQ-045 WAIT_CYCLES=0: back-to-back sw/lw at consecutive RESP cycles -> one stall cycle per access; lw returns the value just stored.

Source files
------------

// File: rtl/dmem_responder.sv
// Purpose : single-port data memory with wait states, byte/half/word lanes and load extension.
// Latency : request seen in IDLE in cycle N -> RESP (data/error valid) in cycle N+WAIT_CYCLES+1.
// Backpressure: MemStallM freezes the pipeline from request acceptance until the RESP cycle.
//
// Ports:
//   clk, reset   single clock, synchronous active-high reset
//   MemReadM     load request          MemWriteM  store request (wins if both high)
//   ALUResultM   byte address          WriteDataM store data, right-justified for sb/sh
//   funct3M      size/sign of access (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   ReadDataM    load result, non-zero only in RESP of a legal load
//   MemStallM    stall request to the hazard unit
//   MisalignM    one-cycle error flag in RESP for misaligned or illegal-size access
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  funct3M,
    output logic [31:0] ReadDataM,
    output logic        MemStallM,
    output logic        MisalignM
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Counter preload; WAIT_CYCLES=0 never enters WAIT so the value is irrelevant there.
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [2:0]      f3_q, f3_d;
    logic            store_q, store_d;
    logic            load_q, load_d;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            req;
    logic            mem_we;
    logic [AW-1:0]   mem_idx;
    logic [31:0]     mem_old;
    logic [31:0]     mem_wdata;
    logic [3:0]      lane_be;
    logic [31:0]     lane_dat;
    logic            resp_err;
    logic [31:0]     rd_word;
    logic [31:0]     load_val;

    // Address bits above the array index are deliberately ignored (wrap-around).
    logic            unused_addr_hi;
    assign unused_addr_hi = ^ALUResultM[31:AW+2];

    // 1 = access cannot be performed: bad size code or misaligned for its size.
    function automatic logic access_err(input logic [2:0] f3, input logic [1:0] a);
        logic e;
        case (f3)
            3'b000, 3'b100: e = 1'b0;
            3'b001, 3'b101: e = a[0];
            3'b010:         e = (a != 2'b00);
            default:        e = 1'b1;
        endcase
        return e;
    endfunction

    // Select and extend the addressed byte/half from a stored word.
    function automatic logic [31:0] format_load(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  v = {{24{b[7]}}, b};
            3'b100:  v = {24'd0, b};
            3'b001:  v = {{16{h[15]}}, h};
            3'b101:  v = {16'd0, h};
            3'b010:  v = word;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // Next-state, latch and store-commit logic.
    always_comb begin
        req     = MemReadM | MemWriteM;
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        store_d = store_q;
        load_d  = load_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = ALUResultM[AW+1:0];
                    wdata_d = WriteDataM;
                    f3_d    = funct3M;
                    store_d = MemWriteM;
                    load_d  = MemReadM & ~MemWriteM;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The _d copies hold the access fields both when accepting straight into
        // RESP (WAIT_CYCLES=0) and when leaving WAIT, so the commit uses them.
        mem_idx = addr_d[AW+1:2];
        mem_old = mem_q[mem_idx];

        case (f3_d[1:0])
            2'b00: begin
                lane_be  = 4'b0001 << addr_d[1:0];
                lane_dat = {4{wdata_d[7:0]}};
            end
            2'b01: begin
                lane_be  = addr_d[1] ? 4'b1100 : 4'b0011;
                lane_dat = {2{wdata_d[15:0]}};
            end
            default: begin
                lane_be  = 4'b1111;
                lane_dat = wdata_d;
            end
        endcase

        for (int i = 0; i < 4; i++) begin
            mem_wdata[8*i +: 8] = lane_be[i] ? lane_dat[8*i +: 8] : mem_old[8*i +: 8];
        end

        // Commit on the edge entering RESP; a reset in that cycle cancels it.
        mem_we = (state_d == S_RESP) && (state_q != S_RESP) && store_d &&
                 !access_err(f3_d, addr_d[1:0]) && !reset;
    end

    // Response outputs: all are forced low while reset is asserted.
    always_comb begin
        resp_err  = access_err(f3_q, addr_q[1:0]);
        rd_word   = mem_q[addr_q[AW+1:2]];
        load_val  = format_load(rd_word, f3_q, addr_q[1:0]);
        MemStallM = !reset && (((state_q == S_IDLE) && req) || (state_q == S_WAIT));
        MisalignM = !reset && (state_q == S_RESP) && resp_err;
        ReadDataM = 32'd0;
        if (!reset && (state_q == S_RESP) && load_q && !resp_err) begin
            ReadDataM = load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            store_q <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            store_q <= store_d;
            load_q  <= load_d;
        end
    end

    // Storage array is never cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int WC    = 2;
    localparam int MB    = DEPTH * 4;

    logic        clk;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [2:0]  funct3M;
    logic [31:0] ReadDataM;
    logic        MemStallM, MisalignM;

    logic        d0_reset;
    logic        d0_rd, d0_wr;
    logic [31:0] d0_addr, d0_wdat;
    logic [2:0]  d0_f3;
    logic [31:0] d0_rdat;
    logic        d0_stall, d0_mis;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .funct3M(funct3M),
        .ReadDataM(ReadDataM), .MemStallM(MemStallM), .MisalignM(MisalignM)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(d0_reset),
        .MemReadM(d0_rd), .MemWriteM(d0_wr),
        .ALUResultM(d0_addr), .WriteDataM(d0_wdat), .funct3M(d0_f3),
        .ReadDataM(d0_rdat), .MemStallM(d0_stall), .MisalignM(d0_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        string       nm;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mb [MB];
    logic [2:0]  fs [10] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7, 3'd2};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Byte-addressed reference memory: little-endian, address wraps modulo size.
    task automatic model_access(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] d, input logic [2:0] f3,
                                output logic [31:0] rdata, output logic mis);
        int          sz;
        int          base;
        logic [31:0] v;
        sz = 0;
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 0;
        endcase
        mis   = (sz == 0) || ((a % sz) != 0);
        base  = int'(a % MB);
        rdata = 32'd0;
        if (!mis) begin
            if (wr) begin
                for (int i = 0; i < sz; i++) mb[(base + i) % MB] = d[8*i +: 8];
            end else if (rd) begin
                v = 32'd0;
                for (int i = 0; i < sz; i++) v = v | (32'(mb[(base + i) % MB]) << (8 * i));
                if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
                rdata = v;
            end
        end
    endtask

    task automatic set_idle();
        MemReadM = 1'b0; MemWriteM = 1'b0;
        ALUResultM = 32'd0; WriteDataM = 32'd0; funct3M = 3'd0;
    endtask

    // Issue one access at a negedge in IDLE; push expectation; count stall cycles.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [2:0] f3,
                             input bit use_c, input logic [31:0] c_data, input logic c_mis,
                             input string nm);
        exp_t        e;
        logic [31:0] md;
        logic        mm;
        int          n;
        model_access(rd, wr, a, d, f3, md, mm);
        e.data = use_c ? c_data : md;
        e.mis  = use_c ? c_mis  : mm;
        e.nm   = nm;
        sbq.push_back(e);
        MemReadM = rd; MemWriteM = wr; ALUResultM = a; WriteDataM = d; funct3M = f3;
        #1;
        n = 0;
        while (MemStallM && n < 50) begin
            n++;
            @(negedge clk);
            if (n == 1) begin
                // Inputs must be ignored once the access is latched.
                MemReadM = 1'($urandom); MemWriteM = 1'($urandom);
                ALUResultM = $urandom; WriteDataM = $urandom; funct3M = 3'($urandom);
            end
            #1;
        end
        chk({nm, "_stall_cycles"}, 32'(n), 32'(WC + 1));
        set_idle();
        @(negedge clk);
    endtask

    // Store that is hit by reset either mid-WAIT (cancelled) or in RESP (kept).
    task automatic do_reset_store(input bit in_wait, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] md;
        logic        mm;
        int          n;
        MemReadM = 1'b0; MemWriteM = 1'b1; ALUResultM = a; WriteDataM = d; funct3M = 3'd2;
        @(negedge clk);
        if (in_wait) begin
            reset = 1'b1;
            set_idle();
        end else begin
            #1;
            n = 0;
            while (MemStallM && n < 50) begin
                n++;
                @(negedge clk);
                #1;
            end
            chk("rst_resp_reach", 32'(n), 32'(WC));
            reset = 1'b1;
            set_idle();
            model_access(1'b0, 1'b1, a, d, 3'd2, md, mm);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk(in_wait ? "rst_wait_idle_stall" : "rst_resp_idle_stall", 32'(MemStallM), 32'd0);
    endtask

    // Monitor: a RESP cycle is the first non-stall cycle after a stall cycle.
    initial begin
        logic prev_stall;
        exp_t e;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                chk("rst_stall", 32'(MemStallM), 32'd0);
                chk("rst_rdata", ReadDataM, 32'd0);
                chk("rst_mis", 32'(MisalignM), 32'd0);
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && !MemStallM) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got data 0x%08h with no pending access", ReadDataM);
                    end else begin
                        e = sbq.pop_front();
                        chk({e.nm, "_rdata"}, ReadDataM, e.data);
                        chk({e.nm, "_mis"}, 32'(MisalignM), 32'(e.mis));
                    end
                end else begin
                    chk("idle_rdata_zero", ReadDataM, 32'd0);
                    chk("idle_mis_zero", 32'(MisalignM), 32'd0);
                end
                prev_stall = MemStallM;
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rd, wr;
        logic [31:0] a;
        logic [2:0]  f3;
        int          r;

        reset = 1'b1; d0_reset = 1'b1;
        set_idle();
        d0_rd = 1'b0; d0_wr = 1'b0; d0_addr = 32'd0; d0_wdat = 32'd0; d0_f3 = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0; d0_reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++)
            do_access(1'b0, 1'b1, 32'(i * 4), 32'd0, 3'd2, 1'b1, 32'd0, 1'b0, "init");

        do_access(0, 1, 32'h10, 32'hDEADBEEF, 3'd2, 1, 32'd0, 0, "sw_10");
        do_access(1, 0, 32'h10, 32'd0, 3'd2, 1, 32'hDEADBEEF, 0, "lw_10");
        do_access(0, 1, 32'h11, 32'h7F, 3'd0, 1, 32'd0, 0, "sb_11");
        do_access(1, 0, 32'h10, 32'd0, 3'd2, 1, 32'hDEAD7FEF, 0, "lw_10_sb");
        do_access(1, 0, 32'h13, 32'd0, 3'd0, 1, 32'hFFFFFFDE, 0, "lb_13");
        do_access(1, 0, 32'h13, 32'd0, 3'd4, 1, 32'h000000DE, 0, "lbu_13");
        do_access(1, 0, 32'h12, 32'd0, 3'd1, 1, 32'hFFFFDEAD, 0, "lh_12");
        do_access(1, 0, 32'h10, 32'd0, 3'd5, 1, 32'h00007FEF, 0, "lhu_10");
        do_access(1, 0, 32'h12, 32'd0, 3'd2, 1, 32'd0, 1, "lw_12_mis");
        do_access(0, 1, 32'h11, 32'hBEEF, 3'd1, 1, 32'd0, 1, "sh_11_mis");
        do_access(1, 0, 32'h10, 32'd0, 3'd2, 1, 32'hDEAD7FEF, 0, "lw_10_after_mis");
        do_access(1, 0, 32'h10, 32'd0, 3'd3, 1, 32'd0, 1, "f3_011_illegal");
        do_access(0, 1, 32'h10, 32'h0, 3'd7, 1, 32'd0, 1, "f3_111_illegal");
        do_access(1, 1, 32'h14, 32'h01020304, 3'd2, 1, 32'd0, 0, "rdwr_is_store");
        do_access(1, 0, 32'h14, 32'd0, 3'd2, 1, 32'h01020304, 0, "lw_14");
        do_access(0, 1, 32'h100, 32'h12345678, 3'd2, 1, 32'd0, 0, "sw_100");
        do_access(1, 0, 32'h0, 32'd0, 3'd2, 1, 32'h12345678, 0, "lw_0_wrap");

        do_reset_store(1'b1, 32'h20, 32'hAAAAAAAA);
        do_access(1, 0, 32'h20, 32'd0, 3'd2, 1, 32'd0, 0, "lw_20_cancelled");
        do_reset_store(1'b0, 32'h24, 32'h55555555);
        do_access(1, 0, 32'h24, 32'd0, 3'd2, 1, 32'h55555555, 0, "lw_24_kept");
        do_access(1, 0, 32'h10, 32'd0, 3'd2, 1, 32'hDEAD7FEF, 0, "lw_10_after_rst");

        for (int k = 0; k < 300; k++) begin
            r  = int'($urandom_range(0, 2));
            rd = (r != 1);
            wr = (r != 0);
            f3 = fs[$urandom_range(0, 9)];
            a  = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
            do_access(rd, wr, a, $urandom, f3, 1'b0, 32'd0, 1'b0, "rand");
        end

        // Zero-wait instance: one stall cycle per access, back-to-back.
        d0_wr = 1'b1; d0_rd = 1'b0; d0_addr = 32'h40; d0_wdat = 32'hCAFEF00D; d0_f3 = 3'd2;
        #1;
        chk("wc0_sw_stall", 32'(d0_stall), 32'd1);
        @(negedge clk);
        #1;
        chk("wc0_sw_resp_stall", 32'(d0_stall), 32'd0);
        chk("wc0_sw_resp_rdata", d0_rdat, 32'd0);
        chk("wc0_sw_resp_mis", 32'(d0_mis), 32'd0);
        d0_wr = 1'b0; d0_rd = 1'b1; d0_wdat = 32'd0;
        @(negedge clk);
        #1;
        chk("wc0_lw_stall", 32'(d0_stall), 32'd1);
        @(negedge clk);
        #1;
        chk("wc0_lw_resp_stall", 32'(d0_stall), 32'd0);
        chk("wc0_lw_resp_rdata", d0_rdat, 32'hCAFEF00D);
        d0_rd = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
